// File: rtl/robot_defs.sv
// Shared encodings for the robot motor path: FSM states, command-byte and rx-byte field positions.
package robot_defs;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REMOTE  = 3'd1,
        ST_STOP    = 3'd2,
        ST_REVERSE = 3'd3,
        ST_TURN    = 3'd4
    } state_e;

    localparam int CMD_EN  = 6;
    localparam int CMD_DIR = 5;
    localparam int RX_MARK = 7;
    localparam int RX_SIDE = 6;
    localparam int RX_DIR  = 5;

    localparam logic DIR_FWD = 1'b1;

    function automatic logic [7:0] make_cmd(input logic en, input logic dir, input logic [4:0] spd);
        make_cmd = {1'b0, en, dir, spd};
    endfunction

    function automatic int max_int(input int a, input int b);
        max_int = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond timer: a TICK_DIV prescaler feeding a saturating ms counter, with synchronous clear.
module ms_timer #(
    parameter int TICK_DIV = 12000,
    parameter int MS_W     = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic [MS_W-1:0] target,
    output logic            done
);

    localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [MS_W-1:0]  MS_MAX   = '1;

    logic [PRE_W-1:0] pre;
    logic [MS_W-1:0]  ms;
    logic             tick;

    assign tick = en && (pre == PRE_LAST);
    // Fires on the final cycle of the interval, so the consumer's state change
    // lands exactly target*TICK_DIV cycles after the clear.
    assign done = tick && (ms == target - MS_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            ms  <= '0;
        end else if (clr) begin
            pre <= '0;
            ms  <= '0;
        end else if (en) begin
            if (pre == PRE_LAST) begin
                pre <= '0;
                if (ms != MS_MAX) ms <= ms + MS_W'(1);
            end else begin
                pre <= pre + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/motor_cmd_arbiter.sv
// Arbitrates remote commands, a bump reflex manoeuvre and a link-loss watchdog into
// registered left/right wheel command bytes.
module motor_cmd_arbiter
    import robot_defs::*;
#(
    parameter int         TICK_DIV = 12000,
    parameter int         WDOG_MS  = 500,
    parameter int         STOP_MS  = 100,
    parameter int         REV_MS   = 300,
    parameter int         TURN_MS  = 250,
    parameter logic [4:0] REV_SPD  = 5'd12,
    parameter logic [4:0] TURN_SPD = 5'd10
) (
    input  logic       WF_CLK,
    input  logic       WF_BUTTON,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic [5:0] bump,
    output logic [7:0] left_cmd,
    output logic [7:0] right_cmd,
    output logic [2:0] state,
    output logic       reflex_active
);

    localparam int MAX_MS = max_int(max_int(WDOG_MS, STOP_MS), max_int(REV_MS, TURN_MS));
    localparam int MS_W   = $clog2(MAX_MS + 1);

    localparam logic [7:0] REV_CMD  = make_cmd(1'b1, ~DIR_FWD, REV_SPD);
    localparam logic [7:0] TURN_FWD = make_cmd(1'b1, DIR_FWD, TURN_SPD);
    localparam logic [7:0] TURN_BCK = make_cmd(1'b1, ~DIR_FWD, TURN_SPD);

    state_e          cur;
    logic            turn_dir;
    logic            bump_any;
    logic            phase_done;
    logic            timer_clr;
    logic [MS_W-1:0] target;
    logic [7:0]      rx_cmd;

    // rx_valid is a one-cycle strobe with no back-pressure: a byte not taken in
    // the cycle it is presented (reflex active, or a bump in the same cycle) is lost.
    assign bump_any = |bump;
    assign rx_cmd   = make_cmd(1'b1, rx_data[RX_DIR], rx_data[4:0]);
    assign state    = cur;

    always_comb begin
        target = MS_W'(WDOG_MS);
        case (cur)
            ST_STOP:    target = MS_W'(STOP_MS);
            ST_REVERSE: target = MS_W'(REV_MS);
            ST_TURN:    target = MS_W'(TURN_MS);
            default:    target = MS_W'(WDOG_MS);
        endcase
    end

    // The single timer restarts on every state entry and, in REMOTE, on every byte.
    always_comb begin
        timer_clr = 1'b1;
        case (cur)
            ST_IDLE:               timer_clr = 1'b1;
            ST_REMOTE:             timer_clr = bump_any || rx_valid;
            ST_STOP, ST_REVERSE:   timer_clr = phase_done;
            ST_TURN:               timer_clr = phase_done || bump_any;
            default:               timer_clr = 1'b1;
        endcase
    end

    ms_timer #(
        .TICK_DIV (TICK_DIV),
        .MS_W     (MS_W)
    ) u_timer (
        .clk    (WF_CLK),
        .rst_n  (WF_BUTTON),
        .clr    (timer_clr),
        .en     (cur != ST_IDLE),
        .target (target),
        .done   (phase_done)
    );

    always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
        if (!WF_BUTTON) begin
            cur           <= ST_IDLE;
            left_cmd      <= '0;
            right_cmd     <= '0;
            reflex_active <= 1'b0;
            turn_dir      <= 1'b0;
        end else begin
            case (cur)
                ST_IDLE, ST_REMOTE: begin
                    if (bump_any) begin
                        cur           <= ST_STOP;
                        turn_dir      <= |bump[2:0];
                        reflex_active <= 1'b1;
                        left_cmd      <= '0;
                        right_cmd     <= '0;
                    end else if (rx_valid && rx_data[RX_MARK]) begin
                        cur <= ST_REMOTE;
                        if (rx_data[RX_SIDE]) right_cmd <= rx_cmd;
                        else                  left_cmd  <= rx_cmd;
                    end else if ((cur == ST_REMOTE) && (rx_valid || phase_done)) begin
                        cur       <= ST_IDLE;
                        left_cmd  <= '0;
                        right_cmd <= '0;
                    end
                end
                ST_STOP: begin
                    if (phase_done) begin
                        cur       <= ST_REVERSE;
                        left_cmd  <= REV_CMD;
                        right_cmd <= REV_CMD;
                    end
                end
                ST_REVERSE: begin
                    if (phase_done) begin
                        cur       <= ST_TURN;
                        left_cmd  <= turn_dir ? TURN_FWD : TURN_BCK;
                        right_cmd <= turn_dir ? TURN_BCK : TURN_FWD;
                    end
                end
                ST_TURN: begin
                    if (bump_any) begin
                        cur       <= ST_STOP;
                        turn_dir  <= |bump[2:0];
                        left_cmd  <= '0;
                        right_cmd <= '0;
                    end else if (phase_done) begin
                        cur           <= ST_IDLE;
                        reflex_active <= 1'b0;
                        left_cmd      <= '0;
                        right_cmd     <= '0;
                    end
                end
                default: begin
                    cur           <= ST_IDLE;
                    reflex_active <= 1'b0;
                    left_cmd      <= '0;
                    right_cmd     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motor_cmd_arbiter.sv
// Bench for motor_cmd_arbiter: vector table, hand-timed manoeuvre sequences, then random traffic
// scored against a deadline-based reference model.
module tb_motor_cmd_arbiter;

    localparam int         TD    = 4;
    localparam int         WDOG  = 500;
    localparam int         STOPM = 100;
    localparam int         REVM  = 300;
    localparam int         TURNM = 250;
    localparam logic [4:0] RSPD  = 5'd12;
    localparam logic [4:0] TSPD  = 5'd10;

    localparam int M_IDLE = 0, M_REMOTE = 1, M_STOP = 2, M_REV = 3, M_TURN = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [5:0] bump = 6'd0;
    logic [7:0] left_cmd, right_cmd;
    logic [2:0] state;
    logic       reflex_active;

    int total = 0;
    int bad   = 0;
    bit use_sb = 1'b0;
    logic [19:0] exp_q[$];

    motor_cmd_arbiter #(.TICK_DIV(TD)) dut (
        .WF_CLK        (clk),
        .WF_BUTTON     (rst_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .bump          (bump),
        .left_cmd      (left_cmd),
        .right_cmd     (right_cmd),
        .state         (state),
        .reflex_active (reflex_active)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Phases are tracked as absolute deadlines in clock edges rather than counters.
    int          m_mode;
    logic [7:0]  m_left, m_right;
    logic        m_td;
    longint      t_now, m_deadline, m_wdog;

    function automatic logic [7:0] cmd(input logic dir, input logic [4:0] spd);
        return {2'b01, dir, spd};
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_left = 8'h00; m_right = 8'h00; m_td = 1'b0;
        t_now = 0; m_deadline = 0; m_wdog = 0;
    endfunction

    function automatic void enter_reflex(input logic [5:0] b);
        m_mode = M_STOP; m_td = |b[2:0]; m_left = 8'h00; m_right = 8'h00;
        m_deadline = t_now + STOPM * TD;
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] d, input logic [5:0] b);
        t_now++;
        case (m_mode)
            M_IDLE, M_REMOTE: begin
                if (|b) enter_reflex(b);
                else if (v && d[7]) begin
                    if (d[6]) m_right = cmd(d[5], d[4:0]);
                    else      m_left  = cmd(d[5], d[4:0]);
                    m_mode = M_REMOTE;
                    m_wdog = t_now + WDOG * TD;
                end else if (m_mode == M_REMOTE && (v || t_now == m_wdog)) begin
                    m_mode = M_IDLE; m_left = 8'h00; m_right = 8'h00;
                end
            end
            M_STOP: if (t_now == m_deadline) begin
                m_mode = M_REV; m_deadline = t_now + REVM * TD;
            end
            M_REV: if (t_now == m_deadline) begin
                m_mode = M_TURN; m_deadline = t_now + TURNM * TD;
            end
            default: begin
                if (|b) enter_reflex(b);
                else if (t_now == m_deadline) begin
                    m_mode = M_IDLE; m_left = 8'h00; m_right = 8'h00;
                end
            end
        endcase
    endfunction

    function automatic logic [19:0] model_out();
        logic [7:0] l, r;
        case (m_mode)
            M_STOP:  begin l = 8'h00; r = 8'h00; end
            M_REV:   begin l = cmd(1'b0, RSPD); r = l; end
            M_TURN:  begin l = cmd(m_td, TSPD); r = cmd(!m_td, TSPD); end
            default: begin l = m_left; r = m_right; end
        endcase
        return {l, r, 3'(m_mode), (m_mode >= M_STOP)};
    endfunction

    // ---------------- driver / checkers ----------------
    task automatic sb_check();
        logic [19:0] e, a;
        a = {left_cmd, right_cmd, state, reflex_active};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: got %h, scoreboard had no expectation", a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                bad++;
                $display("FAIL sb t=%0d: got l=%h r=%h st=%0d ra=%b, want l=%h r=%h st=%0d ra=%b",
                         t_now, a[19:12], a[11:4], a[3:1], a[0], e[19:12], e[11:4], e[3:1], e[0]);
            end
        end
    endtask

    // Called just after a negedge: applies inputs for one edge, checks after the next negedge.
    task automatic drive(input logic v, input logic [7:0] d, input logic [5:0] b);
        rx_valid = v; rx_data = d; bump = b;
        @(posedge clk);
        model_step(v, d, b);
        if (use_sb) exp_q.push_back(model_out());
        @(negedge clk);
        rx_valid = 1'b0; bump = 6'd0;
        if (use_sb) sb_check();
    endtask

    task automatic chk(input string name, input logic [7:0] l, input logic [7:0] r,
                       input logic [2:0] s, input logic ra);
        total++;
        if ({left_cmd, right_cmd, state, reflex_active} !== {l, r, s, ra}) begin
            bad++;
            $display("FAIL %s: got l=%h r=%h st=%0d ra=%b, want l=%h r=%h st=%0d ra=%b",
                     name, left_cmd, right_cmd, state, reflex_active, l, r, s, ra);
        end
    endtask

    // Holds constant inputs for n cycles; outputs must match every cycle (one comparison).
    task automatic run_expect(input string name, input int n, input logic v, input logic [7:0] d,
                              input logic [5:0] b, input logic [7:0] l, input logic [7:0] r,
                              input logic [2:0] s, input logic ra);
        int first_bad;
        logic [19:0] got;
        first_bad = -1;
        got = '0;
        for (int i = 0; i < n; i++) begin
            drive(v, d, b);
            if (first_bad < 0 && {left_cmd, right_cmd, state, reflex_active} !== {l, r, s, ra}) begin
                first_bad = i;
                got = {left_cmd, right_cmd, state, reflex_active};
            end
        end
        total++;
        if (first_bad >= 0) begin
            bad++;
            $display("FAIL %s: cycle %0d got l=%h r=%h st=%0d ra=%b, want l=%h r=%h st=%0d ra=%b",
                     name, first_bad, got[19:12], got[11:4], got[3:1], got[0], l, r, s, ra);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [5:0] b;
        logic [7:0] l;
        logic [7:0] r;
        logic [2:0] s;
        logic       ra;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int seg_len, hold;
        bit rx_on;
        logic v;
        logic [7:0] d;
        logic [5:0] b, bhold;

        vecs[0] = '{1'b1, 8'hBF, 6'b000000, 8'h7F, 8'h00, 3'd1, 1'b0};
        vecs[1] = '{1'b1, 8'hC5, 6'b000000, 8'h7F, 8'h45, 3'd1, 1'b0};
        vecs[2] = '{1'b1, 8'h3F, 6'b000000, 8'h00, 8'h00, 3'd0, 1'b0};
        vecs[3] = '{1'b1, 8'h12, 6'b000000, 8'h00, 8'h00, 3'd0, 1'b0};
        vecs[4] = '{1'b1, 8'hE3, 6'b000000, 8'h00, 8'h63, 3'd1, 1'b0};
        vecs[5] = '{1'b1, 8'h81, 6'b000000, 8'h41, 8'h63, 3'd1, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 6'b000000, 8'h41, 8'h63, 3'd1, 1'b0};
        vecs[7] = '{1'b1, 8'hBF, 6'b010000, 8'h00, 8'h00, 3'd2, 1'b1};

        // reset
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset", 8'h00, 8'h00, 3'd0, 1'b0);
        rst_n = 1'b1;

        // remote decode table, ending in bump+byte same cycle (right-side hit)
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].b);
            chk($sformatf("vec%0d", i), vecs[i].l, vecs[i].r, vecs[i].s, vecs[i].ra);
        end
        run_expect("t4_stop", STOPM*TD - 1, 1'b0, 8'h00, 6'd0, 8'h00, 8'h00, 3'd2, 1'b1);
        run_expect("t4_rev",  REVM*TD,      1'b0, 8'h00, 6'd0, 8'h4C, 8'h4C, 3'd3, 1'b1);
        run_expect("t4_turn", TURNM*TD,     1'b0, 8'h00, 6'd0, 8'h4A, 8'h6A, 3'd4, 1'b1);
        drive(1'b0, 8'h00, 6'd0);
        chk("t4_idle", 8'h00, 8'h00, 3'd0, 1'b0);

        // watchdog, then watchdog restarted by a second byte
        drive(1'b1, 8'hBF, 6'd0);
        chk("t2_load", 8'h7F, 8'h00, 3'd1, 1'b0);
        run_expect("t2_hold", WDOG*TD - 1, 1'b0, 8'h00, 6'd0, 8'h7F, 8'h00, 3'd1, 1'b0);
        drive(1'b0, 8'h00, 6'd0);
        chk("t2_wdog", 8'h00, 8'h00, 3'd0, 1'b0);
        drive(1'b1, 8'hBF, 6'd0);
        run_expect("t2_half", 999, 1'b0, 8'h00, 6'd0, 8'h7F, 8'h00, 3'd1, 1'b0);
        drive(1'b1, 8'hC5, 6'd0);
        run_expect("t2_restart", WDOG*TD - 1, 1'b0, 8'h00, 6'd0, 8'h7F, 8'h45, 3'd1, 1'b0);
        drive(1'b0, 8'h00, 6'd0);
        chk("t2_wdog2", 8'h00, 8'h00, 3'd0, 1'b0);

        // left-side bump pulse in REMOTE: full manoeuvre
        drive(1'b1, 8'hBF, 6'd0);
        drive(1'b0, 8'h00, 6'b000001);
        chk("t3_entry", 8'h00, 8'h00, 3'd2, 1'b1);
        run_expect("t3_stop", STOPM*TD - 1, 1'b0, 8'h00, 6'd0, 8'h00, 8'h00, 3'd2, 1'b1);
        run_expect("t3_rev",  REVM*TD,      1'b0, 8'h00, 6'd0, 8'h4C, 8'h4C, 3'd3, 1'b1);
        run_expect("t3_turn", TURNM*TD,     1'b0, 8'h00, 6'd0, 8'h6A, 8'h4A, 3'd4, 1'b1);
        drive(1'b0, 8'h00, 6'd0);
        chk("t3_idle", 8'h00, 8'h00, 3'd0, 1'b0);

        // bytes and bumps ignored in STOP/REVERSE, bump in TURN restarts with new side
        drive(1'b0, 8'h00, 6'b001000);
        chk("t5_entry", 8'h00, 8'h00, 3'd2, 1'b1);
        run_expect("t5_stop_rx", STOPM*TD - 1, 1'b1, 8'hC5, 6'd0, 8'h00, 8'h00, 3'd2, 1'b1);
        run_expect("t5_rev_rx", 10, 1'b1, 8'hBF, 6'b000001, 8'h4C, 8'h4C, 3'd3, 1'b1);
        run_expect("t5_rev", REVM*TD - 10, 1'b0, 8'h00, 6'd0, 8'h4C, 8'h4C, 3'd3, 1'b1);
        run_expect("t5_turn", 500, 1'b0, 8'h00, 6'd0, 8'h4A, 8'h6A, 3'd4, 1'b1);
        drive(1'b0, 8'h00, 6'b000100);
        chk("t5_rebump", 8'h00, 8'h00, 3'd2, 1'b1);
        run_expect("t5_stop2", STOPM*TD - 1, 1'b0, 8'h00, 6'd0, 8'h00, 8'h00, 3'd2, 1'b1);
        run_expect("t5_rev2",  REVM*TD,      1'b0, 8'h00, 6'd0, 8'h4C, 8'h4C, 3'd3, 1'b1);
        run_expect("t5_turn2", TURNM*TD,     1'b0, 8'h00, 6'd0, 8'h6A, 8'h4A, 3'd4, 1'b1);
        drive(1'b0, 8'h00, 6'd0);
        chk("t5_idle", 8'h00, 8'h00, 3'd0, 1'b0);

        // asynchronous reset during REVERSE
        drive(1'b0, 8'h00, 6'b100000);
        run_expect("t6_stop", STOPM*TD - 1, 1'b0, 8'h00, 6'd0, 8'h00, 8'h00, 3'd2, 1'b1);
        run_expect("t6_rev", 100, 1'b0, 8'h00, 6'd0, 8'h4C, 8'h4C, 3'd3, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk("t6_async", 8'h00, 8'h00, 3'd0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_expect("t6_wait", 50, 1'b0, 8'h00, 6'd0, 8'h00, 8'h00, 3'd0, 1'b0);

        // random traffic against the reference model
        use_sb = 1'b1;
        hold = 0;
        bhold = 6'd0;
        for (int seg = 0; seg < 8; seg++) begin
            seg_len = $urandom_range(200, 2600);
            rx_on = ($urandom_range(0, 2) != 0);
            for (int c = 0; c < seg_len; c++) begin
                v = rx_on && ($urandom_range(0, 14) == 0);
                d = 8'($urandom);
                if ($urandom_range(0, 4) != 0) d[7] = 1'b1;
                if (hold > 0) begin
                    hold--;
                    b = bhold;
                end else if ($urandom_range(0, 1199) == 0) begin
                    bhold = 6'($urandom_range(1, 63));
                    hold = $urandom_range(0, 5);
                    b = bhold;
                end else begin
                    b = 6'd0;
                end
                drive(v, d, b);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
